// File: rtl/perf_csr_reader.sv
// perf_csr_reader: extends the free-running 32-bit cycle/instret counters to
// 64 bits by counting wrap-arounds, and serves counter CSR reads.
//
// Handshake: a request is accepted on a rising clk edge where csr_req=1 and
// csr_ready=1 (csr_ready is high only in IDLE); csr_addr is sampled on that
// edge only. The response is registered on the next edge (CAPTURE) and
// csr_rvalid then stays high with csr_rdata/csr_err stable until an edge
// where csr_rready=1, after which the reader returns to IDLE.
//
// A low-half read latches the matching upper half. The next high-half read of
// the same counter returns that latched value, so a lo/hi pair is a consistent
// 64-bit snapshot.
module perf_csr_reader #(
  parameter int HI_W     = 32,
  parameter bit MMODE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cycle_counter,
  input  logic [31:0] instret_counter,
  input  logic        csr_req,
  input  logic [11:0] csr_addr,
  output logic        csr_ready,
  output logic        csr_rvalid,
  input  logic        csr_rready,
  output logic [31:0] csr_rdata,
  output logic        csr_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [11:0]     r_addr;
  logic [31:0]     r_prev_cyc;
  logic [31:0]     r_prev_ins;
  logic [HI_W-1:0] r_hi_cyc;
  logic [HI_W-1:0] r_hi_ins;
  logic [31:0]     r_snap_cyc;
  logic [31:0]     r_snap_ins;
  logic            r_snap_vld_cyc;
  logic            r_snap_vld_ins;
  logic [31:0]     r_rdata;
  logic            r_err;

  logic            w_wrap_cyc;
  logic            w_wrap_ins;
  logic [HI_W-1:0] w_hi_live_cyc;
  logic [HI_W-1:0] w_hi_live_ins;
  logic [31:0]     w_hi_ext_cyc;
  logic [31:0]     w_hi_ext_ins;
  logic            w_lo_cyc;
  logic            w_lo_ins;
  logic            w_hi_cyc;
  logic            w_hi_ins;

  // Any decrease of a counter input counts as one wrap; the upper half seen
  // this cycle already includes that wrap.
  assign w_wrap_cyc    = (cycle_counter < r_prev_cyc);
  assign w_wrap_ins    = (instret_counter < r_prev_ins);
  assign w_hi_live_cyc = r_hi_cyc + HI_W'(w_wrap_cyc);
  assign w_hi_live_ins = r_hi_ins + HI_W'(w_wrap_ins);

  // Zero-extend the live upper halves to 32 bits for narrow HI_W.
  always_comb begin
    w_hi_ext_cyc = '0;
    w_hi_ext_ins = '0;
    w_hi_ext_cyc[HI_W-1:0] = w_hi_live_cyc;
    w_hi_ext_ins[HI_W-1:0] = w_hi_live_ins;
  end

  // Address decode of the latched request; machine aliases only when enabled.
  always_comb begin
    w_lo_cyc = 1'b0;
    w_lo_ins = 1'b0;
    w_hi_cyc = 1'b0;
    w_hi_ins = 1'b0;
    case (r_addr)
      12'hC00, 12'hC01: w_lo_cyc = 1'b1;
      12'hC02:          w_lo_ins = 1'b1;
      12'hC80, 12'hC81: w_hi_cyc = 1'b1;
      12'hC82:          w_hi_ins = 1'b1;
      12'hB00:          w_lo_cyc = MMODE_EN;
      12'hB02:          w_lo_ins = MMODE_EN;
      12'hB80:          w_hi_cyc = MMODE_EN;
      12'hB82:          w_hi_ins = MMODE_EN;
      default:          ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    w_next     = r_state;
    csr_ready  = 1'b0;
    csr_rvalid = 1'b0;
    case (r_state)
      S_IDLE: begin
        csr_ready = 1'b1;
        if (csr_req) w_next = S_CAPTURE;
      end
      S_CAPTURE: w_next = S_RESP;
      S_RESP: begin
        csr_rvalid = 1'b1;
        if (csr_rready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Wrap tracking, request latch, and response/snapshot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr         <= '0;
      r_prev_cyc     <= '0;
      r_prev_ins     <= '0;
      r_hi_cyc       <= '0;
      r_hi_ins       <= '0;
      r_snap_cyc     <= '0;
      r_snap_ins     <= '0;
      r_snap_vld_cyc <= 1'b0;
      r_snap_vld_ins <= 1'b0;
      r_rdata        <= '0;
      r_err          <= 1'b0;
    end else begin
      r_prev_cyc <= cycle_counter;
      r_prev_ins <= instret_counter;
      r_hi_cyc   <= w_hi_live_cyc;
      r_hi_ins   <= w_hi_live_ins;
      if (r_state == S_IDLE && csr_req) r_addr <= csr_addr;
      if (r_state == S_CAPTURE) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
        if (w_lo_cyc) begin
          r_rdata        <= cycle_counter;
          r_snap_cyc     <= w_hi_ext_cyc;
          r_snap_vld_cyc <= 1'b1;
        end else if (w_lo_ins) begin
          r_rdata        <= instret_counter;
          r_snap_ins     <= w_hi_ext_ins;
          r_snap_vld_ins <= 1'b1;
        end else if (w_hi_cyc) begin
          r_rdata        <= r_snap_vld_cyc ? r_snap_cyc : w_hi_ext_cyc;
          r_snap_vld_cyc <= 1'b0;
        end else if (w_hi_ins) begin
          r_rdata        <= r_snap_vld_ins ? r_snap_ins : w_hi_ext_ins;
          r_snap_vld_ins <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign csr_rdata = r_rdata;
  assign csr_err   = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_perf_csr_reader.sv
// Bench for perf_csr_reader: directed scenarios with literal expectations,
// then randomized counter/read traffic checked every cycle against a 64-bit
// arithmetic model of the extended counters.
module tb_perf_csr_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cycle_counter = '0;
  logic [31:0] instret_counter = '0;
  logic        csr_req = 1'b0;
  logic [11:0] csr_addr = '0;
  logic        csr_rready = 1'b0;
  logic        csr_ready, csr_rvalid, csr_err;
  logic [31:0] csr_rdata;
  logic [1:0]  dbg_state;
  logic        m0_ready, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic [1:0]  m0_dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic cmp_en = 1'b0;
  logic rnd_en = 1'b0;

  perf_csr_reader #(.HI_W(32), .MMODE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .cycle_counter(cycle_counter),
    .instret_counter(instret_counter), .csr_req(csr_req), .csr_addr(csr_addr),
    .csr_ready(csr_ready), .csr_rvalid(csr_rvalid), .csr_rready(csr_rready),
    .csr_rdata(csr_rdata), .csr_err(csr_err), .dbg_state(dbg_state)
  );

  perf_csr_reader #(.HI_W(32), .MMODE_EN(1'b0)) dut_m0 (
    .clk(clk), .rst(rst), .cycle_counter(cycle_counter),
    .instret_counter(instret_counter), .csr_req(csr_req), .csr_addr(csr_addr),
    .csr_ready(m0_ready), .csr_rvalid(m0_rvalid), .csr_rready(csr_rready),
    .csr_rdata(m0_rdata), .csr_err(m0_err), .dbg_state(m0_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each counter is tracked as a 64-bit extended value; every cycle it advances
  // by the 32-bit modular distance to the new input, so any decrease crosses
  // into the next upper value.
  logic [63:0] m_ext_c = '0, m_ext_i = '0;
  logic [31:0] m_snap_c = '0, m_snap_i = '0;
  bit          m_vld_c = 0, m_vld_i = 0;
  int          m_phase = 0;        // 0 waiting, 1 request accepted, 2 answering
  logic [11:0] m_addr = '0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;

  always @(posedge clk) begin
    logic [31:0] d;
    logic [63:0] live_c, live_i;
    if (rst) begin
      m_ext_c = '0; m_ext_i = '0; m_vld_c = 0; m_vld_i = 0;
      m_snap_c = '0; m_snap_i = '0; m_phase = 0; m_rdata = '0; m_err = 1'b0;
    end else begin
      d = cycle_counter - m_ext_c[31:0];
      live_c = m_ext_c + {32'd0, d};
      d = instret_counter - m_ext_i[31:0];
      live_i = m_ext_i + {32'd0, d};
      if (m_phase == 0) begin
        if (csr_req) begin m_addr = csr_addr; m_phase = 1; end
      end else if (m_phase == 1) begin
        m_rdata = '0; m_err = 1'b0;
        case (m_addr)
          12'hC00, 12'hC01, 12'hB00: begin
            m_rdata = live_c[31:0]; m_snap_c = live_c[63:32]; m_vld_c = 1;
          end
          12'hC02, 12'hB02: begin
            m_rdata = live_i[31:0]; m_snap_i = live_i[63:32]; m_vld_i = 1;
          end
          12'hC80, 12'hC81, 12'hB80: begin
            m_rdata = m_vld_c ? m_snap_c : live_c[63:32]; m_vld_c = 0;
          end
          12'hC82, 12'hB82: begin
            m_rdata = m_vld_i ? m_snap_i : live_i[63:32]; m_vld_i = 0;
          end
          default: m_err = 1'b1;
        endcase
        m_phase = 2;
      end else if (csr_rready) begin
        m_phase = 0;
      end
      m_ext_c = live_c;
      m_ext_i = live_i;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ready", csr_ready, (m_phase == 0));
      chk("m_rvalid", csr_rvalid, (m_phase == 2));
      if (m_phase == 2) begin
        chk("m_rdata", csr_rdata, m_rdata);
        chk("m_err", csr_err, m_err);
      end
    end
  end

  // ---------------- random counter driver ----------------
  always @(negedge clk) begin
    if (rnd_en) begin
      case ($urandom_range(0, 39))
        0:       cycle_counter = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        1:       cycle_counter = 32'd0;
        2:       instret_counter = 32'hFFFF_FFF8 + $urandom_range(0, 7);
        3:       instret_counter = $urandom_range(0, 3);
        default: begin
          cycle_counter = cycle_counter + (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
          instret_counter = instret_counter + 32'($urandom_range(0, 1));
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  // One complete read: wait for ready, accept, wait for the response, hold
  // rready low for 'hold' cycles while a stray request is presented, then
  // release. d/e are from the MMODE_EN=1 instance, d0/e0 from the other.
  task automatic do_read(input logic [11:0] a, input int hold,
                         output logic [31:0] d, output logic e,
                         output logic [31:0] d0, output logic e0);
    int n;
    int lat;
    d = '0; e = 1'b0; d0 = '0; e0 = 1'b0;
    @(negedge clk);
    csr_req = 1'b1; csr_addr = a; csr_rready = 1'b0;
    n = 0;
    while (!csr_ready && n < 50) begin @(negedge clk); n++; end
    if (!csr_ready) begin
      chk("ready_timeout", 64'(csr_ready), 64'd1);
      csr_req = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    csr_req = 1'b0;
    csr_addr = 12'($urandom);
    while (!csr_rvalid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    chk("latency", 64'(lat), 64'd2);
    d = csr_rdata; e = csr_err; d0 = m0_rdata; e0 = m0_err;
    for (int k = 0; k < hold; k++) begin
      csr_req = 1'b1; csr_addr = 12'hC82;
      @(negedge clk);
      chk("hold_rvalid", 64'(csr_rvalid), 64'd1);
      chk("hold_ready", 64'(csr_ready), 64'd0);
    end
    csr_req = 1'b0;
    csr_rready = 1'b1;
    @(negedge clk);
    csr_rready = 1'b0;
    chk("idle_ready", 64'(csr_ready), 64'd1);
    chk("idle_rvalid", 64'(csr_rvalid), 64'd0);
  endtask

  task automatic wrap_cycle();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cycle_counter = 32'hFFFF_FFFE + 32'(k);
    end
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] d, d0;
  logic        e, e0;
  logic [11:0] addr_tab [12];

  initial begin
    addr_tab = '{12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82,
                 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0, 12'hC03};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_ready", 64'(csr_ready), 64'd1);
    chk("rst_rvalid", 64'(csr_rvalid), 64'd0);
    chk("rst_rdata", 64'(csr_rdata), 64'd0);
    chk("rst_err", 64'(csr_err), 64'd0);

    cycle_counter = 32'h10;
    do_read(12'hC00, 0, d, e, d0, e0);
    chk("c00_rdata", 64'(d), 64'h10);
    chk("c00_err", 64'(e), 64'd0);
    do_read(12'hC80, 0, d, e, d0, e0);
    chk("c80_snap0", 64'(d), 64'd0);

    wrap_cycle();
    do_read(12'hC80, 0, d, e, d0, e0);
    chk("c80_wrap1", 64'(d), 64'd1);
    wrap_cycle();
    do_read(12'hC80, 0, d, e, d0, e0);
    chk("c80_wrap2", 64'(d), 64'd2);

    instret_counter = 32'hFFFF_FFFF;
    do_read(12'hC02, 0, d, e, d0, e0);
    chk("c02_rdata", 64'(d), 64'hFFFF_FFFF);
    @(negedge clk); instret_counter = 32'd0;
    do_read(12'hC82, 0, d, e, d0, e0);
    chk("c82_snap", 64'(d), 64'd0);
    do_read(12'hC82, 0, d, e, d0, e0);
    chk("c82_live", 64'(d), 64'd1);

    do_read(12'h7C0, 0, d, e, d0, e0);
    chk("illegal_err", 64'(e), 64'd1);
    chk("illegal_rdata", 64'(d), 64'd0);
    do_read(12'hB00, 0, d, e, d0, e0);
    chk("b00_m1_err", 64'(e), 64'd0);
    chk("b00_m1_rdata", 64'(d), 64'd3);
    chk("b00_m0_err", 64'(e0), 64'd1);
    chk("b00_m0_rdata", 64'(d0), 64'd0);

    cycle_counter = 32'h55;
    do_read(12'hC00, 4, d, e, d0, e0);
    chk("hold_rdata", 64'(d), 64'h55);

    // Reset while a request is in CAPTURE.
    @(negedge clk);
    csr_req = 1'b1; csr_addr = 12'hC00;
    @(negedge clk);
    csr_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstcap_rvalid", 64'(csr_rvalid), 64'd0);
    chk("rstcap_ready", 64'(csr_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstcap_no_resp", 64'(csr_rvalid), 64'd0);
    end
    do_read(12'hC80, 0, d, e, d0, e0);
    chk("rstcap_c80", 64'(d), 64'd0);

    // Randomized traffic; the compare process checks every cycle.
    rnd_en = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) == 0) csr_addr = 12'($urandom);
      do_read(($urandom_range(0, 7) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 11)],
              $urandom_range(0, 3), d, e, d0, e0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rnd_en = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
